// File: rtl/proc_setup.sv
// Board-level accumulator demo: switches feed a prescaled add/subtract into a
// 24-bit accumulator shown on six hex displays. Optional macro LEADING_ZERO_BLANK_EN.
module proc_setup #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic [0:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX5,
  output logic [6:0] HEX4,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic [9:0] LEDR
);

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned SW_W   = 10;
  localparam int unsigned LED_W  = 10;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned HEX_W  = DIGITS * SEG_W;
  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [HEX_W-1:0] HEX_RST = {{(DIGITS-1){SEG_BLANK}}, SEG_ZERO};
`else
  localparam logic [HEX_W-1:0] HEX_RST = {DIGITS{SEG_ZERO}};
`endif

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
  function automatic logic [SEG_W-1:0] seg7(input logic [DIG_W-1:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [LED_W-1:0] ledr_q, ledr_d;
  logic [HEX_W-1:0] hex_q, hex_d;

  logic             run_s, sub_s, tick;
  logic [OP_W-1:0]  op_s;
  logic [ACC_W:0]   sum, diff;
  logic [DIG_W-1:0] digit;
  logic             lead, blank;

  assign run_s = sw_sync_q[9];
  assign sub_s = sw_sync_q[8];
  assign op_s  = sw_sync_q[OP_W-1:0];
  assign tick  = run_s && (cnt_q == TICK_MAX);
  // Bit ACC_W is the add carry-out, or the borrow when op_s > acc_q
  assign sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(op_s);
  assign diff  = (ACC_W+1)'(acc_q) - (ACC_W+1)'(op_s);

  // Prescaler and accumulator next state
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    if (!run_s || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (tick) begin
      {carry_d, acc_d} = sub_s ? diff : sum;
    end
  end

  // Display next state, scanned from the most-significant digit down
  always_comb begin
    ledr_d = {run_s, carry_q, acc_q[7:0]};
    hex_d  = '0;
    lead   = 1'b1;
    digit  = '0;
    blank  = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      digit = acc_q[i*DIG_W +: DIG_W];
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = lead && (digit == '0) && (i != 0);
`endif
      hex_d[i*SEG_W +: SEG_W] = blank ? SEG_BLANK : seg7(digit);
      if (digit != '0) begin
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (KEY[0]) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ledr_q    <= '0;
      hex_q     <= HEX_RST;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      ledr_q    <= ledr_d;
      hex_q     <= hex_d;
    end
  end

  assign LEDR = ledr_q;
  assign HEX5 = hex_q[5*SEG_W +: SEG_W];
  assign HEX4 = hex_q[4*SEG_W +: SEG_W];
  assign HEX3 = hex_q[3*SEG_W +: SEG_W];
  assign HEX2 = hex_q[2*SEG_W +: SEG_W];
  assign HEX1 = hex_q[1*SEG_W +: SEG_W];
  assign HEX0 = hex_q[0*SEG_W +: SEG_W];

endmodule

// File: tb/tb_proc_setup.sv
// Directed bench for proc_setup: a per-cycle vector table on a TICK_DIV=1 instance
// plus a hand sequence on a TICK_DIV=4 instance for prescale and freeze/resume.
module tb_proc_setup;

  logic       clk = 1'b0;
  logic [0:0] key;
  logic [9:0] sw;
  logic [6:0] a5, a4, a3, a2, a1, a0;
  logic [9:0] ledr_a;
  logic [6:0] b5, b4, b3, b2, b1, b0;
  logic [9:0] ledr_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_setup #(.TICK_DIV(1)) dut1 (
    .CLOCK_50(clk), .KEY(key), .SW(sw),
    .HEX5(a5), .HEX4(a4), .HEX3(a3), .HEX2(a2), .HEX1(a1), .HEX0(a0),
    .LEDR(ledr_a)
  );

  proc_setup #(.TICK_DIV(4)) dut4 (
    .CLOCK_50(clk), .KEY(key), .SW(sw),
    .HEX5(b5), .HEX4(b4), .HEX3(b3), .HEX2(b2), .HEX1(b1), .HEX0(b0),
    .LEDR(ledr_b)
  );

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] acc);
    logic [41:0] r;
    logic [3:0]  d;
    logic        lead;
    logic        blank;
    r    = '0;
    lead = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      d     = acc[i*4 +: 4];
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = lead && (d == 4'h0) && (i != 0);
`endif
      r[i*7 +: 7] = blank ? 7'b1111111 : seg(d);
      if (d != 4'h0) lead = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [9:0] ledr_act,
                       input logic [41:0] hex_act, input logic [9:0] ledr_exp,
                       input logic [23:0] acc_exp);
    logic [41:0] hex_exp;
    hex_exp = exp_hex(acc_exp);
    total++;
    if (ledr_act !== ledr_exp) begin
      bad++;
      $display("FAIL %s LEDR got=%h exp=%h", name, ledr_act, ledr_exp);
    end
    total++;
    if (hex_act !== hex_exp) begin
      bad++;
      $display("FAIL %s HEX got=%h exp=%h (acc %h)", name, hex_act, hex_exp, acc_exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic       key;
    logic [9:0] sw;
    int         n;
    bit         every;
    logic [9:0] ledr;
    logic [23:0] acc;
  } vec_t;

  localparam int NV = 36;
  vec_t tbl [NV];

  initial begin
    // Each row: drive key/sw, run n edges, expect LEDR and the displayed acc.
    tbl[0]  = '{1'b1, 10'h000, 1,  1'b0, 10'h000, 24'h000000};
    tbl[1]  = '{1'b0, 10'h000, 20, 1'b1, 10'h000, 24'h000000};
    tbl[2]  = '{1'b0, 10'h203, 2,  1'b0, 10'h000, 24'h000000};
    tbl[3]  = '{1'b0, 10'h203, 1,  1'b0, 10'h200, 24'h000000};
    tbl[4]  = '{1'b0, 10'h203, 1,  1'b0, 10'h203, 24'h000003};
    tbl[5]  = '{1'b0, 10'h203, 9,  1'b0, 10'h21E, 24'h00001E};
    tbl[6]  = '{1'b1, 10'h000, 1,  1'b0, 10'h000, 24'h000000};
    tbl[7]  = '{1'b0, 10'h202, 1,  1'b0, 10'h000, 24'h000000};
    tbl[8]  = '{1'b0, 10'h000, 3,  1'b0, 10'h002, 24'h000002};
    tbl[9]  = '{1'b0, 10'h303, 1,  1'b0, 10'h002, 24'h000002};
    tbl[10] = '{1'b0, 10'h000, 3,  1'b0, 10'h1FF, 24'hFFFFFF};
    tbl[11] = '{1'b0, 10'h200, 1,  1'b0, 10'h1FF, 24'hFFFFFF};
    tbl[12] = '{1'b0, 10'h000, 3,  1'b0, 10'h0FF, 24'hFFFFFF};
    tbl[13] = '{1'b1, 10'h000, 1,  1'b0, 10'h000, 24'h000000};
    tbl[14] = '{1'b0, 10'h302, 1,  1'b0, 10'h000, 24'h000000};
    tbl[15] = '{1'b0, 10'h000, 3,  1'b0, 10'h1FE, 24'hFFFFFE};
    tbl[16] = '{1'b0, 10'h203, 3,  1'b0, 10'h3FE, 24'hFFFFFE};
    tbl[17] = '{1'b0, 10'h203, 1,  1'b0, 10'h301, 24'h000001};
    tbl[18] = '{1'b0, 10'h203, 1,  1'b0, 10'h204, 24'h000004};
    tbl[19] = '{1'b1, 10'h203, 1,  1'b0, 10'h000, 24'h000000};
    tbl[20] = '{1'b0, 10'h203, 2,  1'b0, 10'h000, 24'h000000};
    tbl[21] = '{1'b0, 10'h203, 1,  1'b0, 10'h200, 24'h000000};
    tbl[22] = '{1'b0, 10'h203, 1,  1'b0, 10'h203, 24'h000003};
    tbl[23] = '{1'b1, 10'h000, 1,  1'b0, 10'h000, 24'h000000};
    tbl[24] = '{1'b0, 10'h344, 1,  1'b0, 10'h000, 24'h000000};
    tbl[25] = '{1'b0, 10'h000, 3,  1'b0, 10'h1BC, 24'hFFFFBC};
    tbl[26] = '{1'b0, 10'h357, 1,  1'b0, 10'h1BC, 24'hFFFFBC};
    tbl[27] = '{1'b0, 10'h000, 3,  1'b0, 10'h065, 24'hFFFF65};
    tbl[28] = '{1'b0, 10'h2FF, 1,  1'b0, 10'h065, 24'hFFFF65};
    tbl[29] = '{1'b0, 10'h000, 3,  1'b0, 10'h164, 24'h000064};
    tbl[30] = '{1'b0, 10'h276, 1,  1'b0, 10'h164, 24'h000064};
    tbl[31] = '{1'b0, 10'h000, 3,  1'b0, 10'h0DA, 24'h0000DA};
    tbl[32] = '{1'b0, 10'h29E, 1,  1'b0, 10'h0DA, 24'h0000DA};
    tbl[33] = '{1'b0, 10'h000, 3,  1'b0, 10'h078, 24'h000178};
    tbl[34] = '{1'b0, 10'h221, 1,  1'b0, 10'h078, 24'h000178};
    tbl[35] = '{1'b0, 10'h000, 3,  1'b0, 10'h099, 24'h000199};

    key = 1'b1;
    sw  = '0;

    for (int r = 0; r < NV; r++) begin
      key = tbl[r].key;
      sw  = tbl[r].sw;
      for (int c = 0; c < tbl[r].n; c++) begin
        step(1);
        if (tbl[r].every || c == tbl[r].n - 1) begin
          check($sformatf("row%0d.c%0d", r, c), ledr_a,
                {a5, a4, a3, a2, a1, a0}, tbl[r].ledr, tbl[r].acc);
        end
      end
    end

    // Prescaled instance: one step every 4 cycles, freeze and resume
    key = 1'b1; sw = 10'h000;
    step(1);
    check("div4_reset", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h000, 24'h0);
    key = 1'b0; sw = 10'h201;
    step(6);
    check("div4_pre_tick", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h200, 24'h0);
    step(1);
    check("div4_tick1", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h201, 24'h1);
    step(3);
    check("div4_hold", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h201, 24'h1);
    step(1);
    check("div4_tick2", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h202, 24'h2);
    sw = 10'h001;
    step(10);
    check("div4_frozen", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h002, 24'h2);
    sw = 10'h201;
    step(6);
    check("div4_resume_wait", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h202, 24'h2);
    step(1);
    check("div4_resume_tick", ledr_b, {b5, b4, b3, b2, b1, b0}, 10'h203, 24'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_setup.md
Name: proc_setup

Overview:
- Board-level demo wrapper for the DE1-SoC style I/O set: switches, one pushbutton, 50 MHz clock, ten LEDs, six seven-segment displays.
- Holds a 24-bit accumulator. While Run is set, it adds or subtracts an 8-bit switch operand once per prescaler tick.
- Shows the accumulator on HEX5..HEX0 and status/low byte on LEDR.
- Sits at the top of the design, directly on the board pins.

Parameters:
- TICK_DIV, 50000000, number of CLOCK_50 cycles per accumulate tick (≥1; benches use 1).

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- KEY  input  1  KEY[0] = reset, synchronous, active-high.
- SW  input  10  SW[9] Run, SW[8] Sub (1 = subtract), SW[7:0] operand.
- HEX5  output  7  accumulator digit [23:20], active-low segments {g,f,e,d,c,b,a}.
- HEX4  output  7  digit [19:16].
- HEX3  output  7  digit [15:12].
- HEX2  output  7  digit [11:8].
- HEX1  output  7  digit [7:4].
- HEX0  output  7  digit [3:0].
- LEDR  output  10  [9] synced Run, [8] carry/borrow of last update, [7:0] accumulator[7:0].

Behaviour:
- Reset (KEY[0]=1 at a rising edge), synchronous and highest priority:
  - acc=0, carry=0, tick counter=0, sync flops=0.
  - LEDR=0; all HEX=7'b1000000 ("0").
- SW passes through a 2-flop synchronizer. run_s, sub_s and op_s are stage-2 outputs; a switch change becomes effective 2 edges later.
- Tick counter:
  - Counts 0..TICK_DIV-1 while run_s=1.
  - tick = run_s && cnt==TICK_DIV-1; cnt wraps to 0 on tick.
  - run_s=0 clears cnt to 0 and freezes acc.
  - TICK_DIV=1: tick=run_s every cycle.
- On tick:
  - sub_s=0: {carry,acc} <= acc + zero-extended op_s (25-bit sum).
  - sub_s=1: acc <= acc - op_s, carry <= 1 if borrow (op_s > acc).
  - Wraps modulo 2^24.
  - carry holds until the next tick.
- op_s=0 on a tick: acc unchanged, carry cleared.
- Sub toggled mid-run: the new mode applies from the first tick after synchronization; cnt is not reset.
- Outputs are registered one cycle after acc/carry/run_s: LEDR and HEX update on the edge after the state change.
- Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset asserted mid-run: state clears at that edge regardless of SW. Counting resumes 2 edges after reset deasserts if SW[9] remains 1.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any HEX5..HEX1 digit that is zero and has all more-significant digits zero shows blank (7'b1111111).
  - HEX0 always displays its digit.
  - Reset state shows HEX5..HEX1 blank, HEX0 "0".
- Undefined: all six digits always decoded, zeros shown as "0".

Test Plan:
- Reset: KEY[0]=1 for 1 edge, SW=0 -> LEDR=0, all HEX=1000000, and they stay so with KEY[0]=0 and SW[9]=0 for 20 cycles.
- Add run, TICK_DIV=1: deassert reset, SW=10'b1000000011.
  - acc increments by 3 per cycle from edge 3 after SW set.
  - After 10 ticks: acc=0x00001E, LEDR[7:0]=0x1E, LEDR[9]=1, LEDR[8]=0, HEX1=1111001, HEX0=0000110, HEX5..HEX2=1000000.
- Subtract with borrow: acc=0x000002, SW=10'b1100000011 -> acc=0xFFFFFF, LEDR[8]=1, HEX5..HEX0 all 0001110.
- Wrap with carry: acc=0xFFFFFE, SW=10'b1000000011 -> acc=0x000001, LEDR[8]=1; next tick acc=0x000004, LEDR[8]=0.
- Prescale, TICK_DIV=4, SW=10'b1000000001 -> acc steps by 1 every 4 cycles. Clearing SW[9] freezes acc; re-setting SW[9] resumes after 2 sync edges plus 4 cycles.
- Mid-run reset: KEY[0]=1 for one edge while running -> LEDR=0, HEX all "0" (or blank per macro); counting restarts after release.
